// File: rtl/spart_bus_if.sv
// spart_bus_if: SPART bus control strobes and SPART status flags shared by master and SPART
interface spart_bus_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_bus_master.sv
// spart_bus_master: programs the SPART baud divisor, buffers received bytes in a FIFO (SPART_ECHO_EN drains them to TX)
module spart_bus_master #(
  parameter int CLK_HZ     = 50000000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  br_cfg,
  spart_bus_if.master                 bus,
  inout  wire  [7:0]                  databus,
  output logic                        rx_valid,
  output logic [7:0]                  rx_data,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  function automatic logic [15:0] div_of(input int code);
    int baud;
    baud = 4800 << code;
    return 16'((CLK_HZ + 8 * baud) / (16 * baud) - 1);
  endfunction
  localparam logic [15:0] DIV [4] = '{div_of(0), div_of(1), div_of(2), div_of(3)};
  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR} state_t;
  state_t        state_q, state_d;
  logic [1:0]    cfg_q, cfg_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    dout;
  logic          push, pop, full, empty, wr_cond;
  assign full       = count_q[AW];
  assign empty      = count_q == '0;
  assign fifo_count = count_q;
  assign rx_data    = mem_q[rd_ptr_q];
  assign push       = state_q == RD;
  assign databus    = (bus.iocs && !bus.iorw) ? dout : 8'hzz;
`ifdef SPART_ECHO_EN
  logic unused_rx_ready;
  assign unused_rx_ready = rx_ready;
  assign wr_cond  = !empty && bus.tbr;
  assign rx_valid = 1'b0;
  assign pop      = state_q == WR;
`else
  logic unused_tbr;
  assign unused_tbr = bus.tbr;
  assign wr_cond  = 1'b0;
  assign rx_valid = !empty && !rst;
  assign pop      = rx_valid && rx_ready;
`endif
  // bus access decode and next state; reset forces the bus idle
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b00;
    dout       = 8'h00;
    case (state_q)
      CFG_LO: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b10;
        dout       = DIV[br_cfg][7:0];
        cfg_d      = br_cfg;
        state_d    = CFG_HI;
      end
      CFG_HI: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b11;
        dout       = DIV[cfg_q][15:8];
        state_d    = IDLE;
      end
      IDLE: state_d = (br_cfg != cfg_q) ? CFG_LO : (bus.rda && !full) ? RD : wr_cond ? WR : IDLE;
      RD: begin
        bus.iocs = 1'b1;
        state_d  = IDLE;
      end
      WR: begin
        bus.iocs = 1'b1;
        bus.iorw = 1'b0;
        dout     = mem_q[rd_ptr_q];
        state_d  = IDLE;
      end
      default: state_d = CFG_LO;
    endcase
    if (rst) begin
      bus.iocs   = 1'b0;
      bus.iorw   = 1'b1;
      bus.ioaddr = 2'b00;
    end
  end
  // FIFO pointer and occupancy updates; pointers wrap naturally at the power-of-two depth
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CFG_LO;
      cfg_q    <= 2'b00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // FIFO storage captures the SPART byte on the edge that ends a read cycle
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= databus;
  end
endmodule
